// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace checker.
//   trace_entry_t : one expected commit {addr, data, dc}
//   state_t       : checker FSM states
package trace_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            dc;    // data is don't-care (no writeback)
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

endpackage

// File: rtl/trace_checker_if.sv
// Expected-entry load port (valid/ready) and processor commit-trace port.
//   master : drives expected entries and commits, observes exp_rdy
//   slave  : the checker
interface trace_checker_if;
    import trace_pkg::*;

    logic            exp_val;
    logic            exp_rdy;
    logic [XLEN-1:0] exp_addr;
    logic [XLEN-1:0] exp_data;
    logic            exp_dc;
    logic            trace_val;
    logic [XLEN-1:0] trace_addr;
    logic [XLEN-1:0] trace_data;

    modport master (
        output exp_val, exp_addr, exp_data, exp_dc,
        output trace_val, trace_addr, trace_data,
        input  exp_rdy
    );

    modport slave (
        input  exp_val, exp_addr, exp_data, exp_dc,
        input  trace_val, trace_addr, trace_data,
        output exp_rdy
    );
endinterface

// File: rtl/trace_fifo.sv
// Circular buffer of expected trace entries; head is read combinationally.
//   clk, rst   : clock, async active-high reset
//   push, din  : write din when not full
//   pop        : drop the head when not empty
//   dout       : current head entry
//   count      : entries held (0..DEPTH); full / empty flags
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  trace_entry_t             din,
    input  logic                     pop,
    output trace_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= CW'(count + CW'(push_ok) - CW'(pop_ok));
        end
    end
endmodule

// File: rtl/trace_checker.sv
// Checks processor commits in order against a preloaded queue of expected
// (addr, data) entries and reports a sticky verdict.
//   clk, rst     : clock, async active-high reset
//   start        : one-cycle pulse that begins checking
//   io           : expected-entry load port and commit-trace port
//   busy         : checking in progress
//   pass / fail  : sticky verdict; timeout marks a fail caused by silence
//   check_count  : entries matched (saturating)
//   err_idx/addr/data : sequence number and commit captured at the failure
module trace_checker
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    trace_checker_if.slave      io,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [CNT_W-1:0]    check_count,
    output logic [CNT_W-1:0]    err_idx,
    output logic [XLEN-1:0]     err_addr,
    output logic [XLEN-1:0]     err_data
);
    localparam int unsigned QCNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_nx;
    logic [IDLE_W-1:0]   idle_q, idle_nx;
    logic [CNT_W-1:0]    seq_q, seq_nx;
    logic [CNT_W-1:0]    check_nx, err_idx_nx;
    logic [XLEN-1:0]     err_addr_nx, err_data_nx;
    logic                timeout_nx;
    logic                exp_rdy_q, exp_rdy_nx;

    logic                push, pop, match;
    trace_entry_t        din, head;
    logic [QCNT_W-1:0]   q_count, q_count_nx;
    logic                q_full, q_empty;

    assign din.addr   = io.exp_addr;
    assign din.data   = io.exp_data;
    assign din.dc     = io.exp_dc;
    assign io.exp_rdy = exp_rdy_q;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Next-state, queue control and capture values.
    always_comb begin
        state_nx    = state_q;
        idle_nx     = idle_q;
        seq_nx      = seq_q;
        check_nx    = check_count;
        err_idx_nx  = err_idx;
        err_addr_nx = err_addr;
        err_data_nx = err_data;
        timeout_nx  = timeout;
        push        = 1'b0;
        pop         = 1'b0;
        match       = 1'b0;

        case (state_q)
            IDLE: begin
                push = io.exp_val && exp_rdy_q && !q_full;
                if (start) begin
                    // An entry loaded in the start cycle is part of the run.
                    if (q_count == '0 && !push) begin
                        state_nx = PASS;
                    end else begin
                        state_nx = RUN;
                        idle_nx  = '0;
                        seq_nx   = '0;
                        check_nx = '0;
                    end
                end
            end
            RUN: begin
                if (io.trace_val) begin
                    match = !q_empty && (io.trace_addr == head.addr) &&
                            (head.dc || (io.trace_data == head.data));
                    if (match) begin
                        pop      = 1'b1;
                        idle_nx  = '0;
                        seq_nx   = seq_q + CNT_W'(1);
                        check_nx = (check_count != '1) ? check_count + CNT_W'(1) : check_count;
                        if (q_count == QCNT_W'(1)) state_nx = PASS;
                    end else begin
                        state_nx    = FAIL;
                        err_idx_nx  = seq_q;
                        err_addr_nx = io.trace_addr;
                        err_data_nx = io.trace_data;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_nx    = FAIL;
                    timeout_nx  = 1'b1;
                    err_idx_nx  = seq_q;
                    err_addr_nx = '0;
                    err_data_nx = '0;
                end else begin
                    idle_nx = idle_q + IDLE_W'(1);
                end
            end
            default: ;  // PASS / FAIL are terminal until reset
        endcase

        q_count_nx = QCNT_W'(q_count + QCNT_W'(push) - QCNT_W'(pop));
        exp_rdy_nx = (state_nx == IDLE) && (q_count_nx != QCNT_W'(DEPTH));
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idle_q      <= '0;
            seq_q       <= '0;
            exp_rdy_q   <= 1'b1;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            check_count <= '0;
            err_idx     <= '0;
            err_addr    <= '0;
            err_data    <= '0;
        end else begin
            state_q     <= state_nx;
            idle_q      <= idle_nx;
            seq_q       <= seq_nx;
            exp_rdy_q   <= exp_rdy_nx;
            busy        <= (state_nx == RUN);
            pass        <= (state_nx == PASS);
            fail        <= (state_nx == FAIL);
            timeout     <= timeout_nx;
            check_count <= check_nx;
            err_idx     <= err_idx_nx;
            err_addr    <= err_addr_nx;
            err_data    <= err_data_nx;
        end
    end
endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed scenarios, expected
// verdicts queued as each scenario is driven and compared when the DUT
// raises pass or fail.
module tb_trace_checker;
    import trace_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic        p;
        logic        f;
        logic        t;
        logic [7:0]  cc;
        logic [7:0]  idx;
        logic [31:0] a;
        logic [31:0] d;
    } verdict_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, pass, fail, timeout;
    logic [7:0]  check_count, err_idx;
    logic [31:0] err_addr, err_data;

    int total = 0;
    int bad   = 0;
    verdict_t sb[$];

    trace_checker_if bus ();

    trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .io          (bus),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .check_count (check_count),
        .err_idx     (err_idx),
        .err_addr    (err_addr),
        .err_data    (err_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        rst            = 1'b1;
        start          = 1'b0;
        bus.exp_val    = 1'b0;
        bus.exp_addr   = '0;
        bus.exp_data   = '0;
        bus.exp_dc     = 1'b0;
        bus.trace_val  = 1'b0;
        bus.trace_addr = '0;
        bus.trace_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_one(input logic [31:0] a, input logic [31:0] d, input logic dc);
        bus.exp_val  = 1'b1;
        bus.exp_addr = a;
        bus.exp_data = d;
        bus.exp_dc   = dc;
        @(negedge clk);
        bus.exp_val  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d);
        bus.trace_val  = 1'b1;
        bus.trace_addr = a;
        bus.trace_data = d;
        @(negedge clk);
        bus.trace_val  = 1'b0;
    endtask

    task automatic expect_verdict(input logic p, input logic f, input logic t, input logic [7:0] cc,
                                  input logic [7:0] idx, input logic [31:0] a, input logic [31:0] d);
        verdict_t v;
        v = '{p: p, f: f, t: t, cc: cc, idx: idx, a: a, d: d};
        sb.push_back(v);
    endtask

    // Waits (bounded) for a verdict and compares it against the oldest expectation.
    task automatic check_verdict(input string tag);
        verdict_t v;
        int n = 0;
        while (!(pass || fail) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_verdict_seen"}, 32'(pass || fail), 32'd1);
        check_eq({tag, "_exclusive"}, 32'(pass && fail), 32'd0);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            v = sb.pop_front();
            check_eq({tag, "_pass"},    32'(pass),        32'(v.p));
            check_eq({tag, "_fail"},    32'(fail),        32'(v.f));
            check_eq({tag, "_timeout"}, 32'(timeout),     32'(v.t));
            check_eq({tag, "_count"},   32'(check_count), 32'(v.cc));
            check_eq({tag, "_err_idx"}, 32'(err_idx),     32'(v.idx));
            check_eq({tag, "_err_addr"}, err_addr,        v.a);
            check_eq({tag, "_err_data"}, err_data,        v.d);
            check_eq({tag, "_busy"},    32'(busy),        32'd0);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_busy",    32'(busy),        32'd0);
        check_eq("rst_pass",    32'(pass),        32'd0);
        check_eq("rst_fail",    32'(fail),        32'd0);
        check_eq("rst_timeout", 32'(timeout),     32'd0);
        check_eq("rst_count",   32'(check_count), 32'd0);
        check_eq("rst_err_idx", 32'(err_idx),     32'd0);
        check_eq("rst_err_addr", err_addr,        32'd0);
        check_eq("rst_err_data", err_data,        32'd0);
        check_eq("rst_exp_rdy", 32'(bus.exp_rdy), 32'd1);

        // Basic match with a don't-care data entry
        load_one(32'h200, 32'h1, 1'b0);
        load_one(32'h204, 32'h0, 1'b1);
        expect_verdict(1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 32'h0, 32'h0);
        pulse_start();
        check_eq("basic_busy", 32'(busy), 32'd1);
        check_eq("basic_rdy_run", 32'(bus.exp_rdy), 32'd0);
        commit(32'h200, 32'h1);
        check_eq("basic_mid_pass", 32'(pass), 32'd0);
        check_eq("basic_mid_count", 32'(check_count), 32'd1);
        commit(32'h204, 32'hdead);
        check_verdict("basic");

        // Data mismatch on the second entry
        do_reset();
        load_one(32'h200, 32'h5, 1'b0);
        load_one(32'h204, 32'h6, 1'b0);
        expect_verdict(1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 32'h204, 32'h7);
        pulse_start();
        commit(32'h200, 32'h5);
        commit(32'h204, 32'h7);
        check_verdict("data_mis");

        // Address mismatch (wrong branch outcome)
        do_reset();
        load_one(32'h208, 32'h11, 1'b0);
        expect_verdict(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'h20c, 32'h11);
        pulse_start();
        commit(32'h20c, 32'h11);
        check_verdict("addr_mis");

        // Timeout: fail visible exactly TIMEOUT cycles after the start edge
        do_reset();
        load_one(32'h400, 32'h1, 1'b0);
        expect_verdict(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 32'h0, 32'h0);
        pulse_start();
        repeat (TIMEOUT - 1) @(negedge clk);
        check_eq("to_early_fail", 32'(fail), 32'd0);
        check_eq("to_early_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("to_on_time", 32'(fail), 32'd1);
        check_verdict("timeout");

        // Start with an empty queue passes immediately
        do_reset();
        expect_verdict(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h0, 32'h0);
        pulse_start();
        check_eq("empty_pass_now", 32'(pass), 32'd1);
        check_verdict("empty");

        // Load and start in the same cycle: the entry is checked
        do_reset();
        start = 1'b1;
        load_one(32'h500, 32'h77, 1'b0);
        start = 1'b0;
        check_eq("ldstart_busy", 32'(busy), 32'd1);
        expect_verdict(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 32'h0, 32'h0);
        commit(32'h500, 32'h77);
        check_verdict("ldstart");

        // Full queue with pointer wrap
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            check_eq($sformatf("full_rdy%0d", i), 32'(bus.exp_rdy), 32'd1);
            load_one(32'h200 + 32'(4 * i), 32'h1000 + 32'(i * 3), 1'b0);
        end
        check_eq("full_rdy_low", 32'(bus.exp_rdy), 32'd0);
        load_one(32'hbad0, 32'hbad0, 1'b0);   // offered while full: not accepted
        expect_verdict(1'b1, 1'b0, 1'b0, 8'd16, 8'd0, 32'h0, 32'h0);
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) begin
            commit(32'h200 + 32'(4 * i), 32'h1000 + 32'(i * 3));
            repeat (2) @(negedge clk);
        end
        check_verdict("full");
        load_one(32'h600, 32'h1, 1'b0);
        pulse_start();
        check_eq("post_rdy", 32'(bus.exp_rdy), 32'd0);
        check_eq("post_pass", 32'(pass), 32'd1);
        check_eq("post_busy", 32'(busy), 32'd0);
        check_eq("post_count", 32'(check_count), 32'd16);

        // Reset in the middle of a run discards the queue
        do_reset();
        for (int i = 0; i < 5; i++) load_one(32'h700 + 32'(4 * i), 32'(i), 1'b0);
        pulse_start();
        for (int i = 0; i < 3; i++) commit(32'h700 + 32'(4 * i), 32'(i));
        check_eq("mid_count3", 32'(check_count), 32'd3);
        check_eq("mid_busy", 32'(busy), 32'd1);
        do_reset();
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_count", 32'(check_count), 32'd0);
        check_eq("mid_rst_rdy", 32'(bus.exp_rdy), 32'd1);
        load_one(32'h900, 32'h9, 1'b0);
        expect_verdict(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 32'h0, 32'h0);
        pulse_start();
        commit(32'h900, 32'h9);
        check_verdict("mid_rerun");

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesizable consumer for the processor commit-trace interface (trace_val/trace_addr/trace_data).
- Compares each committed trace entry, in order, against a queue of expected (addr, data) entries loaded beforehand through a valid/ready port.
- Reports pass/fail, the first mismatch, and a timeout when commits stop arriving.
- Sits beside the processor in FPGA bring-up and self-checking testbenches, replacing per-entry checks done in tasks.

Parameters:
- DEPTH, 16, number of expected entries held; power of two, at least 2.
- TIMEOUT, 64, maximum cycles between accepted commits while running before fail.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- exp_val  input  1  an expected entry is offered.
- exp_rdy  output  1  the queue accepts the entry; high only in IDLE with the queue not full.
- exp_addr  input  32  expected trace_addr.
- exp_data  input  32  expected trace_data.
- exp_dc  input  1  ignore data for this entry (instructions with no writeback).
- start  input  1  one-cycle pulse; begins checking.
- trace_val  input  1  the processor committed an instruction this cycle.
- trace_addr  input  32  PC of the committed instruction.
- trace_data  input  32  writeback value.
- busy  output  1  state is RUN.
- pass  output  1  sticky; every queued entry matched.
- fail  output  1  sticky; a mismatch or timeout occurred.
- timeout  output  1  sticky; fail was caused by the timeout.
- check_count  output  8  entries matched so far (saturates at 255).
- err_idx  output  8  queue index of the failing entry.
- err_addr  output  32  trace_addr captured at the mismatch.
- err_data  output  32  trace_data captured at the mismatch.

Behaviour:
- Reset values:
  - State IDLE; queue empty; both pointers 0.
  - busy, pass, fail and timeout are 0.
  - check_count, err_idx, err_addr and err_data are 0.
  - exp_rdy is 1 once reset deasserts.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - A load occurs on exp_val and exp_rdy: write {addr, data, dc} at wr_ptr, then increment wr_ptr and count.
  - exp_rdy = (count != DEPTH).
  - trace_val is ignored.
  - start with count == 0 goes directly to PASS.
  - start with count > 0 goes to RUN, clears the idle-cycle counter, and clears check_count.
- RUN, per cycle with trace_val = 1:
  - A match is trace_addr == q.addr and (q.dc or trace_data == q.data).
  - On a match: advance rd_ptr, decrement count, increment check_count, clear the idle counter.
  - If that was the last entry (count == 1), go to PASS in the same edge.
  - On a mismatch: capture err_idx = the entry's sequence number (rd_ptr offset from start), err_addr and err_data; go to FAIL.
- RUN, per cycle with trace_val = 0:
  - Increment the idle counter.
  - When the counter reaches TIMEOUT-1 with no commit, go to FAIL with timeout = 1, err_idx = the current entry's sequence number, and err_addr/err_data = 0.
- PASS and FAIL:
  - Terminal; outputs hold.
  - start and exp_val are ignored; exp_rdy = 0.
  - Only rst leaves these states.
- Latency: the verdict is visible the cycle after the deciding commit's edge. pass and fail are never both 1.
- Loading and start in the same cycle in IDLE: the entry is written first and count includes it, so it is checked.
- Pointers wrap modulo DEPTH; a full queue (count == DEPTH) is legal and checked entirely.
- Reset mid-RUN: everything returns to reset values; the queue contents are discarded.
- All comparisons are full 32-bit equality, with no X handling in RTL.

Decomposition:
- Shared package trace_pkg:
  - typedef trace_entry_t {addr[31:0], data[31:0], dc}.
  - Enum state_t {IDLE, RUN, PASS, FAIL}.
  - Constant CNT_W = 8.
- One sub-module, trace_fifo: parameterized circular buffer with push/pop, count, full and empty. It has no bypass, and its head is read combinationally.
- trace_checker itself holds the FSM, comparator, counters and capture registers.

Test Plan:
- Basic match: load (0x200,0x1) and (0x204,dc); start; commit 0x200/0x1 then 0x204/0xdead -> pass = 1 after the second commit, check_count = 2, fail = 0.
- Data mismatch: load (0x200,0x5),(0x204,0x6); commit 0x200/0x5 then 0x204/0x7 -> fail = 1, err_idx = 1, err_addr = 0x204, err_data = 0x7, check_count = 1.
- Address mismatch modelling a branch taken wrongly (bne): expect 0x208 and commit 0x20c -> fail = 1, err_addr = 0x20c.
- Timeout: TIMEOUT = 8, load 1 entry, start, hold trace_val = 0 -> fail = 1 and timeout = 1 exactly 8 cycles after start; pass stays 0.
- Full and wrap:
  - Load DEPTH entries with 0x200+4i; exp_rdy drops to 0 after the 16th.
  - Commit all 16 with 2 idle cycles between each -> pass = 1, check_count = 16.
  - A later exp_val is ignored.
- Reset mid-run: after 3 of 5 matches, pulse rst -> busy = 0, check_count = 0, exp_rdy = 1; a fresh 1-entry load and start, then a match -> pass = 1.
